// File: rtl/vector_pkg.sv
`default_nettype none
// ============================================================================
// vector_pkg : shared lane/vector types and skid-buffer state encoding
// Rev 1.0
// ============================================================================
package vector_pkg;

  localparam int c_LANES = 4;
  localparam int c_WIDTH = 32;

  typedef logic [c_WIDTH-1:0] lane_t;
  typedef lane_t vec_t [c_LANES];

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } skid_state_e;

endpackage
`default_nettype wire

// File: rtl/vector_skid_buffer.sv
`default_nettype none
// ============================================================================
// vector_skid_buffer : 2-entry registered output stage (main + skid register)
// Rev 1.0
// ============================================================================
module vector_skid_buffer
  import vector_pkg::*;
#(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  skid_state_e   state_q;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          w_accept;
  logic          w_pop;

  assign w_accept = in_valid && in_ready_q;
  assign w_pop    = out_valid_q && out_ready;

  // in_ready is a pure register so upstream never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          in_ready_q <= 1'b1;
          if (w_accept) begin
            main_q      <= in_data;
            out_valid_q <= 1'b1;
            state_q     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_accept && !w_pop) begin
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
            state_q    <= S_TWO;
          end else if (w_pop && !w_accept) begin
            out_valid_q <= 1'b0;
            state_q     <= S_EMPTY;
          end else if (w_accept) begin
            main_q <= in_data;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= S_ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule
`default_nettype wire

// File: rtl/vector_select_pipe.sv
`default_nettype none
// ============================================================================
// vector_select_pipe : N-source vector operand selector with skid-buffered output
// Optional lane masking via VSEL_LANE_MASK_EN.  Rev 1.0
// ============================================================================
module vector_select_pipe
  import vector_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  parameter  int LANES   = c_LANES,
  parameter  int WIDTH   = c_WIDTH,
  localparam int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SEL_W-1:0]               in_sel,
  input  logic [NUM_SRC*LANES*WIDTH-1:0] in_src,
`ifdef VSEL_LANE_MASK_EN
  input  logic [LANES-1:0]               in_lmask,
`endif
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES*WIDTH-1:0]         out_vec,
  output logic                           sel_err
);

  localparam int VW = LANES * WIDTH;

  logic [VW-1:0] w_sel_vec;
  logic [VW-1:0] w_beat;
  logic          w_err;
  logic          w_accept;
  logic          sel_err_q;

  // Out-of-range selects match no source and therefore fall through as zero.
  always_comb begin
    w_sel_vec = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (in_sel == SEL_W'(k)) w_sel_vec = in_src[k*VW +: VW];
    end
  end

  if (NUM_SRC == (1 << SEL_W)) begin : g_sel_full
    assign w_err = 1'b0;
  end else begin : g_sel_partial
    assign w_err = (in_sel > SEL_W'(NUM_SRC - 1));
  end

`ifdef VSEL_LANE_MASK_EN
  always_comb begin
    w_beat = w_sel_vec;
    for (int i = 0; i < LANES; i++) begin
      if (!in_lmask[i]) w_beat[i*WIDTH +: WIDTH] = '0;
    end
  end
`else
  assign w_beat = w_sel_vec;
`endif

  vector_skid_buffer #(
    .DW(VW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (w_beat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_vec)
  );

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= w_accept && w_err;
  end

  assign sel_err = sel_err_q;

endmodule
`default_nettype wire
